// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard controller. Provides operand forwarding
//               selects, load-use stall/bubble, taken-branch flushes and a
//               RUN/MC_WAIT handshake with a multi-cycle execution unit,
//               including timeout abort.
//               Optional performance counters are enabled by defining
//               PIPE_CTRL_PERF_EN; otherwise stall_cnt/flush_cnt read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic [7:0] MC_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        ex_mc_req,
  input  logic        mc_done,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mc_start,
  output logic        mc_err,
  output logic        busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  // Last timer value of a wait; reaching it without mc_done aborts.
  localparam logic [7:0] C_TMO_LAST = MC_TIMEOUT - 8'd1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_timer;
  logic       r_mc_err;
  logic       w_err_nxt;
  logic       w_load_use;
  logic       w_redirect;

  // ex_reg_write only matters to later stages; the hazard checks here are
  // driven by ex_mem_read for loads.
  logic       w_unused;
  assign w_unused = ex_reg_write;

  assign w_load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                      (((ex_rd == id_rs1) & id_uses_rs1) |
                       ((ex_rd == id_rs2) & id_uses_rs2));
  assign w_redirect = ex_valid & ex_branch_taken;

  // Forwarding selects: youngest producer (MEM) wins over WB; x0 never forwards.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
      fwd_a_sel = 2'b01;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
      fwd_a_sel = 2'b10;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
      fwd_b_sel = 2'b01;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
      fwd_b_sel = 2'b10;
  end

  // Next-state and hazard outputs; redirect dominates load-use and mc_start.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    mc_start    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_redirect) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else begin
          if (w_load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
          if (ex_valid && ex_mc_req) begin
            mc_start = 1'b1;
            if (!mc_done)
              w_state_nxt = ST_MC_WAIT;
          end
        end
      end
      ST_MC_WAIT: begin
        if (mc_done) begin
          w_state_nxt = ST_RUN;
        end else if (r_timer == C_TMO_LAST) begin
          w_state_nxt = ST_RUN;
          w_err_nxt   = 1'b1;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State register, wait timer and registered abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_timer  <= 8'd0;
      r_mc_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_err <= w_err_nxt;
      if (r_state == ST_MC_WAIT)
        r_timer <= r_timer + 8'd1;
      else
        r_timer <= 8'd0;
    end
  end

  assign mc_err = r_mc_err;
  assign busy   = (r_state == ST_MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Free-running event counters; wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (stall_if)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush_if_id)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Two instances share the
//               inputs: index 0 uses the default timeout, index 1 uses 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_valid, ex_reg_write, ex_mem_read;
  logic       ex_branch_taken, ex_mc_req, mc_done, mem_reg_write, wb_reg_write;

  logic        stall_if [2];
  logic        stall_id [2];
  logic        stall_ex [2];
  logic        bubble_ex [2];
  logic        flush_if_id [2];
  logic        flush_id_ex [2];
  logic [1:0]  fwd_a_sel [2];
  logic [1:0]  fwd_b_sel [2];
  logic        mc_start [2];
  logic        mc_err [2];
  logic        busy [2];
  logic [31:0] stall_cnt [2];
  logic [31:0] flush_cnt [2];

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl u_dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_req(ex_mc_req), .mc_done(mc_done), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_if(stall_if[0]), .stall_id(stall_id[0]), .stall_ex(stall_ex[0]),
    .bubble_ex(bubble_ex[0]), .flush_if_id(flush_if_id[0]),
    .flush_id_ex(flush_id_ex[0]), .fwd_a_sel(fwd_a_sel[0]),
    .fwd_b_sel(fwd_b_sel[0]), .mc_start(mc_start[0]), .mc_err(mc_err[0]),
    .busy(busy[0]), .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
  );

  pipe_ctrl #(.MC_TIMEOUT(8'd4)) u_dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_req(ex_mc_req), .mc_done(mc_done), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_if(stall_if[1]), .stall_id(stall_id[1]), .stall_ex(stall_ex[1]),
    .bubble_ex(bubble_ex[1]), .flush_if_id(flush_if_id[1]),
    .flush_id_ex(flush_id_ex[1]), .fwd_a_sel(fwd_a_sel[1]),
    .fwd_b_sel(fwd_b_sel[1]), .mc_start(mc_start[1]), .mc_err(mc_err[1]),
    .busy(busy[1]), .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_write = 0;
    ex_mem_read = 0; ex_branch_taken = 0; ex_mc_req = 0; mc_done = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Forwarding rule from the operand-source table.
  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({busy[k], mc_err[k], stall_if[k], stall_ex[k], bubble_ex[k], flush_if_id[k], mc_start[k]} !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b want 0000000", k,
                 {busy[k], mc_err[k], stall_if[k], stall_ex[k], bubble_ex[k], flush_if_id[k], mc_start[k]});
      end
      n_checks++;
      if (stall_cnt[k] !== 32'd0 || flush_cnt[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_cnt[%0d]: got %0d/%0d want 0/0", k, stall_cnt[k], flush_cnt[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    #1;
    n_checks++;
    if ({stall_if[0], stall_id[0], bubble_ex[0], stall_ex[0]} !== 4'b1110) begin
      n_fail++;
      $display("FAIL lu_stall: got %b want 1110", {stall_if[0], stall_id[0], bubble_ex[0], stall_ex[0]});
    end
    tick();
    ex_valid = 0; ex_mem_read = 0;  // bubble now in EX
    #1;
    n_checks++;
    if ({stall_if[0], stall_id[0], bubble_ex[0]} !== 3'b000) begin
      n_fail++;
      $display("FAIL lu_clear: got %b want 000", {stall_if[0], stall_id[0], bubble_ex[0]});
    end
    ex_valid = 1; ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
    #1;
    n_checks++;
    if (stall_id[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_rs2: got %b want 1", stall_id[0]);
    end
    id_uses_rs2 = 0;
    #1;
    n_checks++;
    if (stall_id[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_rs2_unused: got %b want 0", stall_id[0]);
    end
    ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    #1;
    n_checks++;
    if (bubble_ex[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_x0: got %b want 0", bubble_ex[0]);
    end
    idle();
  endtask

  task automatic test_redirect();
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    ex_branch_taken = 1; ex_mc_req = 1;
    #1;
    n_checks++;
    if ({flush_if_id[0], flush_id_ex[0], stall_if[0], bubble_ex[0], mc_start[0]} !== 5'b11000) begin
      n_fail++;
      $display("FAIL redirect: got %b want 11000",
               {flush_if_id[0], flush_id_ex[0], stall_if[0], bubble_ex[0], mc_start[0]});
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_no_mc: got busy %b want 0", busy[0]);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_reg_write = 1; wb_reg_write = 1;
    #1;
    n_checks++;
    if (fwd_a_sel[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_mem_wins: got %b want 01", fwd_a_sel[0]);
    end
    mem_reg_write = 0; ex_rs2 = 7;
    #1;
    n_checks++;
    if (fwd_a_sel[0] !== 2'b10 || fwd_b_sel[0] !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_wb: got %b/%b want 10/10", fwd_a_sel[0], fwd_b_sel[0]);
    end
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    #1;
    n_checks++;
    if (fwd_a_sel[0] !== 2'b00 || fwd_b_sel[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_x0: got %b/%b want 00/00", fwd_a_sel[0], fwd_b_sel[0]);
    end
    idle();
  endtask

  task automatic test_mc_done();
    do_reset();
    ex_valid = 1; ex_mc_req = 1;
    #1;
    n_checks++;
    if (mc_start[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_start: got %b busy %b want 1 busy 0", mc_start[0], busy[0]);
    end
    tick();
    for (int i = 1; i <= 10; i++) begin
      mc_done = (i == 10);
      #1;
      n_checks++;
      if ({busy[0], stall_if[0], stall_ex[0], mc_start[0]} !== {1'b1, i != 10, i != 10, 1'b0}) begin
        n_fail++;
        $display("FAIL mc_wait[%0d]: got %b want %b", i,
                 {busy[0], stall_if[0], stall_ex[0], mc_start[0]}, {1'b1, i != 10, i != 10, 1'b0});
      end
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (busy[0] !== 1'b0 || mc_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_done_exit: got busy %b err %b want 0 0", busy[0], mc_err[0]);
    end
    // mc_done already high on the request cycle: pulse but stay in RUN
    ex_valid = 1; ex_mc_req = 1; mc_done = 1;
    #1;
    n_checks++;
    if (mc_start[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_fast_start: got %b want 1", mc_start[0]);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_fast_run: got busy %b want 0", busy[0]);
    end
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      ex_valid = 1; ex_mc_req = 1;
      tick();
      ex_valid = 0; ex_mc_req = 0;
      for (int i = 1; i <= 4; i++) begin
        mc_done = (pass == 1) && (i == 4);
        #1;
        n_checks++;
        if ({busy[1], stall_if[1], mc_err[1]} !== {1'b1, i != 4, 1'b0}) begin
          n_fail++;
          $display("FAIL tmo_wait[%0d.%0d]: got %b want %b", pass, i,
                   {busy[1], stall_if[1], mc_err[1]}, {1'b1, i != 4, 1'b0});
        end
        tick();
      end
      idle();
      #1;
      n_checks++;
      if (busy[1] !== 1'b0 || mc_err[1] !== (pass == 0)) begin
        n_fail++;
        $display("FAIL tmo_exit[%0d]: got busy %b err %b want 0 %b", pass, busy[1], mc_err[1], pass == 0);
      end
      tick();
      #1;
      n_checks++;
      if (mc_err[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_err_pulse[%0d]: got %b want 0", pass, mc_err[1]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ex_valid = 1; ex_mc_req = 1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    idle();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({busy[k], stall_if[k], mc_err[k]} !== 3'b000 || stall_cnt[k] !== 0 || flush_cnt[k] !== 0) begin
        n_fail++;
        $display("FAIL rst_async[%0d]: got %b cnt %0d/%0d want 000 cnt 0/0", k,
                 {busy[k], stall_if[k], mc_err[k]}, stall_cnt[k], flush_cnt[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      n_checks++;
      if ({mc_start[0], mc_err[0], busy[0], mc_start[1], mc_err[1], busy[1]} !== 6'd0) begin
        n_fail++;
        $display("FAIL rst_release[%0d]: got %b want 000000", i,
                 {mc_start[0], mc_err[0], busy[0], mc_start[1], mc_err[1], busy[1]});
      end
    end
  endtask

  task automatic test_random();
    int unsigned tmo [2] = '{255, 4};
    bit          mw [2] = '{0, 0};
    int unsigned mcnt [2] = '{0, 0};
    bit          merr [2] = '{0, 0};
    bit [31:0]   mst [2] = '{0, 0};
    bit [31:0]   mfl [2] = '{0, 0};
    logic [12:0] e, o;
    bit lu, e_fl, e_st, e_sx, e_ms, fin;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7));
      ex_rd  = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7));
      wb_rd  = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      ex_valid = ($urandom_range(0, 3) != 0); ex_reg_write = 1'($urandom);
      ex_mem_read = 1'($urandom); ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mc_req = ($urandom_range(0, 3) == 0); mc_done = ($urandom_range(0, 5) == 0);
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      #1;
      lu = ex_valid && ex_mem_read && ex_rd != 0 &&
           ((ex_rd == id_rs1 && id_uses_rs1) || (ex_rd == id_rs2 && id_uses_rs2));
      for (int k = 0; k < 2; k++) begin
        if (!mw[k]) begin
          e_fl = ex_valid && ex_branch_taken;
          e_st = lu && !e_fl;
          e_sx = 0;
          e_ms = ex_valid && ex_mc_req && !ex_branch_taken;
        end else begin
          fin  = mc_done || (mcnt[k] + 1 >= tmo[k]);
          e_fl = 0; e_st = !fin; e_sx = !fin; e_ms = 0;
        end
        e = {e_st, e_st, e_sx, e_st && !mw[k], e_fl, e_fl, fwd_of(ex_rs1), fwd_of(ex_rs2),
             e_ms, mw[k], merr[k]};
        o = {stall_if[k], stall_id[k], stall_ex[k], bubble_ex[k], flush_if_id[k], flush_id_ex[k],
             fwd_a_sel[k], fwd_b_sel[k], mc_start[k], busy[k], mc_err[k]};
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL rand_ctrl[%0d] cyc %0d: got %b want %b", k, n, o, e);
        end
        n_checks++;
        if (stall_cnt[k] !== (PERF ? mst[k] : 32'd0) || flush_cnt[k] !== (PERF ? mfl[k] : 32'd0)) begin
          n_fail++;
          $display("FAIL rand_cnt[%0d] cyc %0d: got %0d/%0d want %0d/%0d", k, n, stall_cnt[k],
                   flush_cnt[k], PERF ? mst[k] : 0, PERF ? mfl[k] : 0);
        end
        // advance the reference
        if (!mw[k]) begin
          if (e_ms && !mc_done) begin mw[k] = 1; mcnt[k] = 0; end
          merr[k] = 0;
        end else if (mc_done) begin
          mw[k] = 0; merr[k] = 0;
        end else if (mcnt[k] + 1 >= tmo[k]) begin
          mw[k] = 0; merr[k] = 1;
        end else begin
          mcnt[k]++; merr[k] = 0;
        end
        mst[k] += 32'(e_st);
        mfl[k] += 32'(e_fl);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_counters();
    do_reset();
`ifdef PIPE_CTRL_PERF_EN
    force u_dut_a.r_stall_cnt = 32'hFFFFFFFF;
    force u_dut_a.r_flush_cnt = 32'hFFFFFFFF;
    #1;
    release u_dut_a.r_stall_cnt;
    release u_dut_a.r_flush_cnt;
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    #1;
    n_checks++;
    if (stall_cnt[0] !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL cnt_preset: got %h want ffffffff", stall_cnt[0]);
    end
    tick();
    ex_branch_taken = 1;
    #1;
    n_checks++;
    if (stall_cnt[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL cnt_stall_wrap: got %h want 00000000", stall_cnt[0]);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (flush_cnt[0] !== 32'd0 || stall_cnt[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL cnt_flush_wrap: got %h/%h want 0/0", flush_cnt[0], stall_cnt[0]);
    end
`else
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    tick();
    ex_branch_taken = 1;
    tick();
    idle();
    #1;
    n_checks++;
    if (stall_cnt[0] !== 32'd0 || flush_cnt[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL cnt_disabled: got %0d/%0d want 0/0", stall_cnt[0], flush_cnt[0]);
    end
`endif
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_forwarding();
    test_mc_done();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
